// File: rtl/dkong_sound_cmd.sv
// Main-CPU side of the Donkey Kong sound-board command interface: latches 6H/4H, queues 3D codes, runs the 5H/SACK handshake.
// Define SNDCMD_FIFO_EN to queue codes in a FIFO_DEPTH-deep FIFO; otherwise a single latest-wins holding register is used.
module dkong_sound_cmd #(
   parameter int REQ_TIMEOUT = 24576,
   parameter int GAP_CYCLES  = 256,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       W_CLK_24576M,
   input  logic       W_RESETn,
   input  logic       I_DKJR,
   input  logic       I_CPU_WE,
   input  logic [3:0] I_CPU_A,
   input  logic [7:0] I_CPU_D,
   output logic [7:0] O_CPU_D,
   input  logic       I_SACK,
   output logic [6:0] O_6H_Q,
   output logic       O_5H_Q0,
   output logic [1:0] O_4H_Q,
   output logic [4:0] O_3D_Q,
   output logic       O_BUSY,
   output logic [1:0] O_DBG_STATE
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_REQ = 2'd2, ST_GAP = 2'd3} state_t;

   localparam int TMAX = (REQ_TIMEOUT > GAP_CYCLES) ? REQ_TIMEOUT : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX);
   localparam int CW   = $clog2(FIFO_DEPTH + 1);
   localparam logic [TW-1:0] REQ_LAST = TW'(REQ_TIMEOUT - 1);
   localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

   state_t          r_state, w_next_state;
   logic [TW-1:0]   r_timer;
   logic            w_timer_clr, w_timer_inc;
   logic            r_sack_s1, r_sack_s2, r_sack_prev;
   logic            w_sack_rise;
   logic [6:0]      r_6h;
   logic [1:0]      r_4h;
   logic [4:0]      r_3d;
   logic            w_flush, w_push, w_pop, w_empty;
   logic [4:0]      w_push_code, w_head;
   logic [CW-1:0]   w_cnt;
   logic [7:0]      w_cnt8;
   logic            w_unused_d;

   assign w_unused_d  = ^I_CPU_D[7:5];
   assign w_push_code = I_DKJR ? I_CPU_D[4:0] : {1'b0, I_CPU_D[3:0]};
   assign w_flush     = I_CPU_WE && (I_CPU_A == 4'hF) && I_CPU_D[0];
   assign w_push      = I_CPU_WE && (I_CPU_A == 4'h0) && !w_flush;
   assign w_pop       = (r_state == ST_LOAD) && !w_flush && !w_empty;
   assign w_sack_rise = r_sack_s2 & ~r_sack_prev;

   always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
      if (!W_RESETn) begin
         r_sack_s1   <= 1'b0;
         r_sack_s2   <= 1'b0;
         r_sack_prev <= 1'b0;
      end else begin
         r_sack_s1   <= I_SACK;
         r_sack_s2   <= r_sack_s1;
         r_sack_prev <= r_sack_s2;
      end
   end

   // 6H behaves like a 74LS259: address picks the bit, D[0] is the value.
   always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
      if (!W_RESETn) begin
         r_6h <= 7'd0;
         r_4h <= 2'd0;
      end else if (I_CPU_WE) begin
         if (I_CPU_A[3] && (I_CPU_A[2:0] != 3'b111))
            r_6h[I_CPU_A[2:0]] <= I_CPU_D[0];
         if ((I_CPU_A == 4'h2) && I_DKJR)
            r_4h <= I_CPU_D[1:0];
      end
   end

`ifdef SNDCMD_FIFO_EN
   localparam int PW = $clog2(FIFO_DEPTH);
   logic [4:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_full, w_wr_en;

   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_wr_en = w_push && (!w_full || w_pop);
   assign w_empty = (r_count == '0);
   assign w_head  = r_mem[r_rd_ptr];
   assign w_cnt   = r_count;

   always_ff @(posedge W_CLK_24576M) begin
      if (w_wr_en)
         r_mem[r_wr_ptr] <= w_push_code;
   end

   always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
      if (!W_RESETn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_en, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
`else
   logic [4:0] r_hold_code;
   logic       r_hold_valid;

   assign w_empty = !r_hold_valid;
   assign w_head  = r_hold_code;
   assign w_cnt   = CW'(r_hold_valid);

   // A push in the LOAD cycle re-arms the holder with the newer code.
   always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
      if (!W_RESETn) begin
         r_hold_code  <= 5'd0;
         r_hold_valid <= 1'b0;
      end else if (w_flush) begin
         r_hold_valid <= 1'b0;
      end else if (w_push) begin
         r_hold_code  <= w_push_code;
         r_hold_valid <= 1'b1;
      end else if (w_pop) begin
         r_hold_valid <= 1'b0;
      end
   end
`endif

   always_comb begin
      w_next_state = r_state;
      w_timer_clr  = 1'b0;
      w_timer_inc  = 1'b0;
      case (r_state)
         ST_IDLE: if (!w_empty) w_next_state = ST_LOAD;
         ST_LOAD: w_next_state = ST_REQ;
         ST_REQ: begin
            if (w_sack_rise || (r_timer == REQ_LAST)) begin
               w_next_state = ST_GAP;
               w_timer_clr  = 1'b1;
            end else begin
               w_timer_inc  = 1'b1;
            end
         end
         ST_GAP: begin
            if (r_timer == GAP_LAST) begin
               w_next_state = ST_IDLE;
               w_timer_clr  = 1'b1;
            end else begin
               w_timer_inc  = 1'b1;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
      if (w_flush) begin
         w_next_state = ST_IDLE;
         w_timer_clr  = 1'b1;
         w_timer_inc  = 1'b0;
      end
   end

   always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
      if (!W_RESETn) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_3d    <= 5'd0;
      end else begin
         r_state <= w_next_state;
         if (w_timer_clr)      r_timer <= '0;
         else if (w_timer_inc) r_timer <= r_timer + 1'b1;
         if (w_pop)            r_3d    <= w_head;
      end
   end

   assign w_cnt8      = 8'(w_cnt);
   assign O_6H_Q      = r_6h;
   assign O_4H_Q      = r_4h;
   assign O_3D_Q      = r_3d;
   assign O_5H_Q0     = (r_state == ST_REQ);
   assign O_BUSY      = (r_state != ST_IDLE) || (w_cnt != '0);
   assign O_DBG_STATE = r_state;
   assign O_CPU_D     = (I_CPU_A == 4'h0) ?
                        {O_BUSY, w_cnt8[2:0], r_sack_s2, O_5H_Q0, 2'b00} : 8'h00;

endmodule
